// File: rtl/vector_pkg.sv
// Shared vector-unit constants and the load/store sequencer state encoding.
// Also used by the vector decode path.
package vector_pkg;

    localparam int          MAX_LANES   = 5;
    localparam int          VSIZE_W     = 3;
    localparam int          VREG_AW     = 4;
    localparam logic [31:0] ELEM_STRIDE = 32'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT_R = 3'd2,
        WB     = 3'd3,
        DONE   = 3'd4
    } lsu_state_t;

    // Requests larger than the register file width are trimmed to the lane count.
    function automatic logic [VSIZE_W-1:0] clamp_size(input logic [VSIZE_W-1:0] size);
        return (size > VSIZE_W'(MAX_LANES)) ? VSIZE_W'(MAX_LANES) : size;
    endfunction

endpackage

// File: rtl/vlsu_lane_buf.sv
// Lane staging registers for the vector LSU: bulk clear, bulk load of store
// operands, single-lane write of returning load data, all lanes readable at once.
module vlsu_lane_buf
    import vector_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clr,
    input  logic                       load,
    input  logic [MAX_LANES-1:0][31:0] load_data,
    input  logic                       wr_en,
    input  logic [VSIZE_W-1:0]         wr_idx,
    input  logic [31:0]                wr_data,
    output logic [MAX_LANES-1:0][31:0] lanes
);

    logic [31:0] lane_reg [MAX_LANES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_LANES; i++) lane_reg[i] <= '0;
        end else begin
            for (int i = 0; i < MAX_LANES; i++) begin
                if (clr) begin
                    lane_reg[i] <= '0;
                end else if (load) begin
                    lane_reg[i] <= load_data[i];
                end else if (wr_en && wr_idx == VSIZE_W'(i)) begin
                    lane_reg[i] <= wr_data;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < MAX_LANES; gi++) begin : g_lane_out
            assign lanes[gi] = lane_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store sequencer: walks vsize elements through a single-outstanding
// memory port and, for loads, writes all lanes back to the vregfile in one cycle.
module vector_lsu
    import vector_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               is_store,
    input  logic [VSIZE_W-1:0] vsize,
    input  logic [31:0]        base_addr,
    input  logic [VREG_AW-1:0] vwa,
    input  logic [31:0]        vs1,
    input  logic [31:0]        vs2,
    input  logic [31:0]        vs3,
    input  logic [31:0]        vs4,
    input  logic [31:0]        vs5,
    output logic               busy,
    output logic               done,
    output logic               mem_req,
    output logic               mem_we,
    output logic [31:0]        mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [31:0]        mem_rdata,
    output logic               vrf_we,
    output logic               vrf_vector_op,
    output logic [VSIZE_W-1:0] vrf_vector_size,
    output logic [VREG_AW-1:0] vrf_wa,
    output logic [31:0]        vrf_wd1,
    output logic [31:0]        vrf_wd2,
    output logic [31:0]        vrf_wd3,
    output logic [31:0]        vrf_wd4,
    output logic [31:0]        vrf_wd5
);

    lsu_state_t state_reg, state_next;

    logic                       is_store_reg;
    logic [VSIZE_W-1:0]         eff_reg;
    logic [VSIZE_W-1:0]         idx_reg;
    logic [VREG_AW-1:0]         vwa_reg;
    logic [31:0]                addr_reg;
    logic [VSIZE_W-1:0]         vsize_eff;
    logic                       accept;
    logic                       advance;
    logic                       lane_wr;
    logic                       last_elem;
    logic [MAX_LANES-1:0][31:0] lanes;

    assign vsize_eff = clamp_size(vsize);
    assign last_elem = (idx_reg == eff_reg - VSIZE_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        advance    = 1'b0;
        lane_wr    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        vrf_we     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (vsize_eff == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = is_store_reg;
                if (mem_gnt) begin
                    if (is_store_reg) begin
                        advance    = 1'b1;
                        state_next = last_elem ? DONE : REQ;
                    end else begin
                        state_next = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                busy = 1'b1;
                if (mem_rvalid) begin
                    lane_wr    = 1'b1;
                    advance    = 1'b1;
                    state_next = last_elem ? WB : REQ;
                end
            end
            WB: begin
                busy       = 1'b1;
                vrf_we     = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The running address is kept as a register so it wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            is_store_reg <= 1'b0;
            eff_reg      <= '0;
            idx_reg      <= '0;
            vwa_reg      <= '0;
            addr_reg     <= '0;
        end else if (accept) begin
            is_store_reg <= is_store;
            eff_reg      <= vsize_eff;
            idx_reg      <= '0;
            vwa_reg      <= vwa;
            addr_reg     <= base_addr;
        end else if (advance) begin
            idx_reg      <= idx_reg + VSIZE_W'(1);
            addr_reg     <= addr_reg + ELEM_STRIDE;
        end
    end

    vlsu_lane_buf u_lane_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (accept && !is_store),
        .load      (accept && is_store),
        .load_data ({vs5, vs4, vs3, vs2, vs1}),
        .wr_en     (lane_wr),
        .wr_idx    (idx_reg),
        .wr_data   (mem_rdata),
        .lanes     (lanes)
    );

    assign mem_addr        = addr_reg;
    assign mem_wdata       = (state_reg == REQ && is_store_reg) ? lanes[idx_reg] : '0;
    assign vrf_vector_op   = vrf_we;
    assign vrf_vector_size = eff_reg;
    assign vrf_wa          = vwa_reg;
    assign vrf_wd1         = lanes[0];
    assign vrf_wd2         = lanes[1];
    assign vrf_wd3         = lanes[2];
    assign vrf_wd4         = lanes[3];
    assign vrf_wd5         = lanes[4];

endmodule

// File: tb/tb_vector_lsu.sv
// Self-checking bench for vector_lsu: directed scenarios plus randomized operations
// against a word-addressed memory model and per-operation expected transactions.
module tb_vector_lsu;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        is_store;
    logic [2:0]  vsize;
    logic [31:0] base_addr;
    logic [3:0]  vwa;
    logic [31:0] vs1, vs2, vs3, vs4, vs5;
    logic        busy;
    logic        done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        vrf_we;
    logic        vrf_vector_op;
    logic [2:0]  vrf_vector_size;
    logic [3:0]  vrf_wa;
    logic [31:0] vrf_wd1, vrf_wd2, vrf_wd3, vrf_wd4, vrf_wd5;

    vector_lsu dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .is_store        (is_store),
        .vsize           (vsize),
        .base_addr       (base_addr),
        .vwa             (vwa),
        .vs1             (vs1),
        .vs2             (vs2),
        .vs3             (vs3),
        .vs4             (vs4),
        .vs5             (vs5),
        .busy            (busy),
        .done            (done),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_gnt         (mem_gnt),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .vrf_we          (vrf_we),
        .vrf_vector_op   (vrf_vector_op),
        .vrf_vector_size (vrf_vector_size),
        .vrf_wa          (vrf_wa),
        .vrf_wd1         (vrf_wd1),
        .vrf_wd2         (vrf_wd2),
        .vrf_wd3         (vrf_wd3),
        .vrf_wd4         (vrf_wd4),
        .vrf_wd5         (vrf_wd5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model and responder knobs.
    logic [31:0] mem_model [logic [31:0]];
    int          req_seen    = 0;
    int          stall_at    = -1;
    int          stall_left  = 0;
    int          stall_pct   = 0;
    int          stall_total = 0;
    int          delay_total = 0;
    int          rv_min      = 0;
    int          rv_max      = 0;
    bit          spur_en     = 1'b0;
    bit          pending     = 1'b0;
    bit          stall;
    int          delay_left  = 0;
    logic [31:0] pend_addr;
    bit          hold_chk    = 1'b0;
    logic [31:0] hold_addr, hold_wdata;
    logic        hold_we;
    logic [31:0] log_addr  [$];
    logic        log_we    [$];
    logic [31:0] log_wdata [$];

    // Write-back observation.
    int          wb_count = 0;
    int          op_bad   = 0;
    logic [3:0]  wb_wa;
    logic [2:0]  wb_size;
    logic [31:0] wb_wd [5];
    logic [31:0] op_vs [5];

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Memory responder: grants (with optional stalls), returns read data after
    // a programmable delay, and may inject stray rvalid when no load is pending.
    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            pending    = 1'b0;
            hold_chk   = 1'b0;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 32'd0;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (pending) begin
                if (delay_left > 0) begin
                    delay_left--;
                    delay_total++;
                end else begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_rd(pend_addr);
                    pending    = 1'b0;
                end
            end else if (spur_en && $urandom_range(3, 0) == 0) begin
                mem_rvalid = 1'b1;
            end
            if (hold_chk) begin
                check1("hold_req", mem_req, 1'b1);
                check1("hold_we", mem_we, hold_we);
                check32("hold_addr", mem_addr, hold_addr);
                check32("hold_wdata", mem_wdata, hold_wdata);
            end
            hold_chk = 1'b0;
            mem_gnt  = 1'b0;
            if (mem_req === 1'b1) begin
                stall = 1'b0;
                if (req_seen == stall_at && stall_left > 0) begin
                    stall = 1'b1;
                    stall_left--;
                end else if (int'($urandom_range(99, 0)) < stall_pct) begin
                    stall = 1'b1;
                end
                if (stall) begin
                    stall_total++;
                    hold_chk   = 1'b1;
                    hold_addr  = mem_addr;
                    hold_wdata = mem_wdata;
                    hold_we    = mem_we;
                end else begin
                    mem_gnt = 1'b1;
                    log_addr.push_back(mem_addr);
                    log_we.push_back(mem_we);
                    log_wdata.push_back(mem_wdata);
                    req_seen++;
                    if (mem_we === 1'b1) begin
                        mem_model[mem_addr] = mem_wdata;
                    end else begin
                        pending    = 1'b1;
                        pend_addr  = mem_addr;
                        delay_left = int'($urandom_range(rv_max, rv_min));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (vrf_vector_op !== vrf_we) op_bad++;
            if (vrf_we === 1'b1) begin
                wb_count++;
                wb_wa    = vrf_wa;
                wb_size  = vrf_vector_size;
                wb_wd[0] = vrf_wd1;
                wb_wd[1] = vrf_wd2;
                wb_wd[2] = vrf_wd3;
                wb_wd[3] = vrf_wd4;
                wb_wd[4] = vrf_wd5;
            end
        end
    end

    // Presents one request for a single cycle, then scrambles the operands so
    // that only the values latched at accept can influence the operation.
    task automatic launch(input logic st, input logic [2:0] sz, input logic [31:0] base,
                          input logic [3:0] wa);
        log_addr.delete();
        log_we.delete();
        log_wdata.delete();
        req_seen    = 0;
        stall_total = 0;
        delay_total = 0;
        wb_count    = 0;
        op_bad      = 0;
        start       = 1'b1;
        is_store    = st;
        vsize       = sz;
        base_addr   = base;
        vwa         = wa;
        vs1 = op_vs[0]; vs2 = op_vs[1]; vs3 = op_vs[2]; vs4 = op_vs[3]; vs5 = op_vs[4];
        @(negedge clk);
        start     = 1'b0;
        is_store  = ~st;
        vsize     = 3'($urandom);
        base_addr = $urandom;
        vwa       = 4'($urandom);
        vs1 = $urandom; vs2 = $urandom; vs3 = $urandom; vs4 = $urandom; vs5 = $urandom;
    endtask

    task automatic run_op(input logic st, input logic [2:0] sz, input logic [31:0] base,
                          input logic [3:0] wa, input bit poke);
        int          eff;
        int          cyc;
        int          exp_lat;
        int          n;
        logic [31:0] exp_wd [5];
        eff = (sz > 3'd5) ? 5 : int'(sz);
        for (int i = 0; i < 5; i++)
            exp_wd[i] = (!st && i < eff) ? mem_rd(base + 32'(4 * i)) : 32'd0;
        launch(st, sz, base, wa);
        cyc = 1;
        check1("busy_first", busy, eff != 0);
        check1("req_first", mem_req, eff != 0);
        while (done !== 1'b1 && cyc < 400) begin
            if (poke && cyc == 1) begin
                start    = 1'b1;
                is_store = ~st;
                vsize    = 3'd4;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check1("done_seen", done, 1'b1);
        check1("busy_at_done", busy, 1'b0);
        exp_lat = (eff == 0) ? 1 : (st ? eff + 1 : 2 * eff + 2);
        exp_lat = exp_lat + stall_total + delay_total;
        check32("latency", 32'(cyc), 32'(exp_lat));
        if (poke) begin
            start    = 1'b1;
            is_store = 1'b0;
            vsize    = 3'd3;
        end
        @(negedge clk);
        start = 1'b0;
        check1("done_pulse", done, 1'b0);
        check1("idle_after", busy, 1'b0);
        n = log_addr.size();
        check32("req_count", 32'(n), 32'(eff));
        for (int i = 0; i < eff && i < n; i++) begin
            check32("addr", log_addr[i], base + 32'(4 * i));
            check1("we", log_we[i], st);
            check32("wdata", log_wdata[i], st ? op_vs[i] : 32'd0);
        end
        check32("wb_count", 32'(wb_count), (st || eff == 0) ? 32'd0 : 32'd1);
        check32("op_mismatch", 32'(op_bad), 32'd0);
        if (!st && eff != 0 && wb_count == 1) begin
            check32("wb_wa", 32'(wb_wa), 32'(wa));
            check32("wb_size", 32'(wb_size), 32'(eff));
            for (int i = 0; i < 5; i++) check32("wb_wd", wb_wd[i], exp_wd[i]);
        end
        $display("op st=%0d vsize=%0d base=%08h eff=%0d latency=%0d reqs=%0d wb=%0d",
                 st, sz, base, eff, cyc, n, wb_count);
    endtask

    initial begin
        int cyc;
        reset_n   = 1'b0;
        start     = 1'b0;
        is_store  = 1'b0;
        vsize     = 3'd0;
        base_addr = 32'd0;
        vwa       = 4'd0;
        vs1 = 32'd0; vs2 = 32'd0; vs3 = 32'd0; vs4 = 32'd0; vs5 = 32'd0;
        for (int i = 0; i < 5; i++) op_vs[i] = 32'd0;
        repeat (2) @(negedge clk);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_req", mem_req, 1'b0);
        check1("rst_we", mem_we, 1'b0);
        check1("rst_vrf_we", vrf_we, 1'b0);
        check1("rst_vop", vrf_vector_op, 1'b0);
        check32("rst_addr", mem_addr, 32'd0);
        check32("rst_wdata", mem_wdata, 32'd0);
        check32("rst_size", 32'(vrf_vector_size), 32'd0);
        check32("rst_wa", 32'(vrf_wa), 32'd0);
        check32("rst_wd1", vrf_wd1, 32'd0);
        check32("rst_wd5", vrf_wd5, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Load of five from 0x100 returning 3..7.
        for (int i = 0; i < 5; i++) mem_model[32'h100 + 32'(4 * i)] = 32'(3 + i);
        run_op(1'b0, 3'd5, 32'h100, 4'd9, 1'b0);

        // Store of three with the second request stalled for two cycles.
        for (int i = 0; i < 5; i++) op_vs[i] = 32'd2;
        stall_at   = 1;
        stall_left = 2;
        run_op(1'b1, 3'd3, 32'h200, 4'd1, 1'b0);
        stall_at = -1;

        // Zero-length and oversized requests.
        for (int i = 0; i < 5; i++) op_vs[i] = $urandom;
        run_op(1'b0, 3'd0, 32'h300, 4'd2, 1'b0);
        run_op(1'b1, 3'd0, 32'h300, 4'd2, 1'b0);
        run_op(1'b1, 3'd7, 32'h400, 4'd4, 1'b0);
        run_op(1'b0, 3'd7, 32'h400, 4'd5, 1'b0);

        // Address wrap at the top of the address space.
        run_op(1'b0, 3'd3, 32'hFFFF_FFF8, 4'd6, 1'b0);

        // Start pulses while busy and in DONE, plus stray rvalid outside WAIT_R.
        spur_en = 1'b1;
        run_op(1'b0, 3'd4, 32'h500, 4'd7, 1'b1);
        run_op(1'b1, 3'd4, 32'h600, 4'd8, 1'b1);
        spur_en = 1'b0;

        // Reset asserted while waiting for the second element's read data.
        for (int i = 0; i < 5; i++) op_vs[i] = $urandom;
        rv_min = 3;
        rv_max = 3;
        launch(1'b0, 3'd5, 32'h2000, 4'd3);
        cyc = 0;
        while (req_seen < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check1("reach_elem2", req_seen >= 2, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check1("abort_busy", busy, 1'b0);
        check1("abort_done", done, 1'b0);
        check1("abort_req", mem_req, 1'b0);
        check1("abort_vrf_we", vrf_we, 1'b0);
        check32("abort_addr", mem_addr, 32'd0);
        check32("abort_wd1", vrf_wd1, 32'd0);
        check32("abort_size", 32'(vrf_vector_size), 32'd0);
        check32("abort_wa", 32'(vrf_wa), 32'd0);
        @(negedge clk);
        check1("abort_done2", done, 1'b0);
        reset_n = 1'b1;
        rv_min  = 0;
        rv_max  = 0;
        @(negedge clk);
        check1("abort_idle", busy, 1'b0);
        check32("abort_wb", 32'(wb_count), 32'd0);
        $display("reset abort during load element 2 checked");
        run_op(1'b0, 3'd5, 32'h2000, 4'd3, 1'b0);

        // Randomized operations with random stalls, read delays and stray rvalids.
        for (int t = 0; t < 40; t++) begin
            logic [31:0] rbase;
            for (int i = 0; i < 5; i++) op_vs[i] = $urandom;
            stall_pct = int'($urandom_range(30, 0));
            rv_min    = 0;
            rv_max    = int'($urandom_range(2, 0));
            spur_en   = 1'($urandom);
            rbase     = (t % 2 == 0) ? 32'h3000 + 32'(4 * $urandom_range(7, 0)) : $urandom;
            run_op(1'($urandom), 3'($urandom), rbase, 4'($urandom), 1'($urandom));
        end
        stall_pct = 0;
        rv_max    = 0;
        spur_en   = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
